// File: rtl/iter_add_sub_pkg.sv
// Shared types and helpers for the iterative adder/subtractor.
// Optional saturation is enabled by defining SATURATE_EN (see iter_add_sub.sv).
package iter_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Chunk index width; a single-chunk build still needs a 1-bit counter.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/iter_add_sub_rca_chunk.sv
// CHUNK-bit ripple-carry adder built from a chain of 1-bit full adders.
module rca_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/iter_add_sub.sv
// Multi-cycle add/subtract: WIDTH-bit operands summed CHUNK bits per cycle through one adder.
// Define SATURATE_EN to clamp y to the signed limit on overflow; otherwise y wraps.
module iter_add_sub
    import iter_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic               carry, carry_next;
    logic [WIDTH-1:0]   b_q, b_next;
    logic [WIDTH-1:0]   a_eff, a_eff_next;
    logic [WIDTH-1:0]   y_next;
    logic               cout_next, ovf_next;
    logic [CHUNK-1:0]   a_chunk, b_chunk, sum_chunk;
    logic               chunk_carry;

    assign a_chunk = CHUNK'(a_eff >> (CHUNK * idx));
    assign b_chunk = CHUNK'(b_q >> (CHUNK * idx));

    rca_chunk #(.CHUNK(CHUNK)) u_rca (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .s    (sum_chunk),
        .cout (chunk_carry)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            b_q       <= '0;
            a_eff     <= '0;
            y         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            carry     <= carry_next;
            b_q       <= b_next;
            a_eff     <= a_eff_next;
            y         <= y_next;
            cout      <= cout_next;
            ovf       <= ovf_next;
            in_ready  <= (state_next == ST_IDLE);
            out_valid <= (state_next == ST_DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        idx_next   = idx;
        carry_next = carry;
        b_next     = b_q;
        a_eff_next = a_eff;
        y_next     = y;
        cout_next  = cout;
        ovf_next   = ovf;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    b_next     = b;
                    a_eff_next = (sub == OP_SUB) ? ~a : a;
                    carry_next = sub;
                    idx_next   = '0;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                y_next[int'(idx)*CHUNK +: CHUNK] = sum_chunk;
                carry_next = chunk_carry;
                idx_next   = idx + IDX_W'(1);
                if (idx == LAST_IDX) begin
                    cout_next  = chunk_carry;
                    ovf_next   = (b_q[WIDTH-1] == a_eff[WIDTH-1]) &&
                                 (sum_chunk[CHUNK-1] != b_q[WIDTH-1]);
`ifdef SATURATE_EN
                    if (ovf_next) begin
                        y_next = b_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`else
                    // Wrapping result: y already holds the modulo-2^WIDTH sum.
`endif
                    idx_next   = '0;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_iter_add_sub.sv
// Bench for iter_add_sub: a 16/4 instance and an 8/8 (single-cycle BUSY) instance
// checked against an arithmetic reference model; honours SATURATE_EN like the RTL.
module tb_iter_add_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid_w = 1'b0, sub_w = 1'b0, out_ready_w = 1'b0;
    logic [15:0] a_w = '0, b_w = '0;
    logic        in_ready_w, out_valid_w, cout_w, ovf_w;
    logic [15:0] y_w;

    logic        in_valid_n = 1'b0, sub_n = 1'b0, out_ready_n = 1'b0;
    logic [7:0]  a_n = '0, b_n = '0;
    logic        in_ready_n, out_valid_n, cout_n, ovf_n;
    logic [7:0]  y_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iter_add_sub #(.WIDTH(16), .CHUNK(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .sub(sub_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .y(y_w), .cout(cout_w), .ovf(ovf_w)
    );

    iter_add_sub #(.WIDTH(8), .CHUNK(8)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
        .a(a_n), .b(b_n), .sub(sub_n), .out_valid(out_valid_n),
        .out_ready(out_ready_n), .y(y_n), .cout(cout_n), .ovf(ovf_n)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as unsigned and signed values.
    task automatic model(input int w, input logic [15:0] bv, input logic [15:0] av, input logic sv,
                         output logic [15:0] ye, output logic ce, output logic ve);
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint bu   = longint'(bv) & m;
        longint au   = longint'(av) & m;
        longint bs   = (bu >= half) ? bu - (m + 1) : bu;
        longint as_  = (au >= half) ? au - (m + 1) : au;
        longint ru   = sv ? (bu - au + m + 1) : (bu + au);
        longint rs   = sv ? (bs - as_) : (bs + as_);
        ye = 16'(ru & m);
        ce = ((ru >> w) & 1) != 0;
        ve = (rs > half - 1) || (rs < -half);
`ifdef SATURATE_EN
        if (ve) ye = (bs < 0) ? 16'(half) : 16'(half - 1);
`endif
    endtask

    function automatic logic obs_in_ready(input bit nar);
        return nar ? in_ready_n : in_ready_w;
    endfunction
    function automatic logic obs_out_valid(input bit nar);
        return nar ? out_valid_n : out_valid_w;
    endfunction
    function automatic logic [15:0] obs_y(input bit nar);
        return nar ? {8'h00, y_n} : y_w;
    endfunction
    function automatic logic obs_cout(input bit nar);
        return nar ? cout_n : cout_w;
    endfunction
    function automatic logic obs_ovf(input bit nar);
        return nar ? ovf_n : ovf_w;
    endfunction

    task automatic drive_in(input bit nar, input logic v, input logic [15:0] bv,
                            input logic [15:0] av, input logic sv);
        if (nar) begin
            in_valid_n = v; b_n = bv[7:0]; a_n = av[7:0]; sub_n = sv;
        end else begin
            in_valid_w = v; b_w = bv; a_w = av; sub_w = sv;
        end
    endtask

    task automatic set_out_ready(input bit nar, input logic v);
        if (nar) out_ready_n = v;
        else     out_ready_w = v;
    endtask

    // One operation: accept, measure latency, check result, optional DONE backpressure, release.
    task automatic run_op(input string tag, input bit nar, input logic [15:0] bv,
                          input logic [15:0] av, input logic sv, input int hold);
        int nch = nar ? 1 : 4;
        int cyc = 0;
        logic [15:0] ye;
        logic ce, ve;
        model(nar ? 8 : 16, bv, av, sv, ye, ce, ve);
        check({tag, "_in_ready_idle"}, 16'(obs_in_ready(nar)), 16'd1);
        drive_in(nar, 1'b1, bv, av, sv);
        @(posedge clk); #1;
        drive_in(nar, 1'b0, '0, '0, 1'b0);
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!obs_out_valid(nar) && cyc < 20);
        check({tag, "_out_valid"}, 16'(obs_out_valid(nar)), 16'd1);
        check({tag, "_latency"}, 16'(cyc), 16'(nch));
        check({tag, "_y"}, obs_y(nar), ye);
        check({tag, "_cout"}, 16'(obs_cout(nar)), 16'(ce));
        check({tag, "_ovf"}, 16'(obs_ovf(nar)), 16'(ve));
        check({tag, "_in_ready_done"}, 16'(obs_in_ready(nar)), 16'd0);
        for (int i = 0; i < hold; i++) begin
            drive_in(nar, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #1;
            check({tag, "_hold_y"}, obs_y(nar), ye);
            check({tag, "_hold_flags"}, {14'd0, obs_cout(nar), obs_ovf(nar)}, {14'd0, ce, ve});
            check({tag, "_hold_hs"}, {14'd0, obs_out_valid(nar), obs_in_ready(nar)}, 16'b10);
        end
        drive_in(nar, 1'b0, '0, '0, 1'b0);
        set_out_ready(nar, 1'b1);
        @(posedge clk); #1;
        set_out_ready(nar, 1'b0);
        check({tag, "_release"}, {14'd0, obs_out_valid(nar), obs_in_ready(nar)}, 16'b01);
    endtask

    initial begin
        bit seen_valid;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_w", {y_w, 14'd0, cout_w, ovf_w} >> 16 | 16'({out_valid_w, in_ready_w}), 16'b01);
        check("rst_w_y", y_w, 16'h0000);
        check("rst_w_flags", {14'd0, cout_w, ovf_w}, 16'd0);
        check("rst_n_hs", {14'd0, out_valid_n, in_ready_n}, 16'b01);
        check("rst_n_y", {8'h00, y_n}, 16'h0000);

        // Directed cases, 16/4
        run_op("add_basic", 1'b0, 16'h1234, 16'h0001, 1'b0, 0);
        run_op("sub_neg",   1'b0, 16'h0005, 16'h0007, 1'b1, 0);
        run_op("sub_pos",   1'b0, 16'h0007, 16'h0005, 1'b1, 0);
        run_op("add_ovf",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op("sub_ovf",   1'b0, 16'h8000, 16'h0001, 1'b1, 0);
        run_op("backpress", 1'b0, 16'hABCD, 16'h1111, 1'b1, 5);
        repeat (2) @(posedge clk);
        #1 check("no_accept_in_done", {14'd0, out_valid_w, in_ready_w}, 16'b01);

        // Reset in the second BUSY cycle
        drive_in(1'b0, 1'b1, 16'h4321, 16'h1111, 1'b0);
        @(posedge clk); #1;
        drive_in(1'b0, 1'b0, '0, '0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_hs", {14'd0, out_valid_w, in_ready_w}, 16'b01);
        check("midrst_y", y_w, 16'h0000);
        seen_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid_w) seen_valid = 1'b1;
        end
        check("midrst_no_valid", 16'(seen_valid), 16'd0);
        run_op("after_rst", 1'b0, 16'h0F0F, 16'h00F1, 1'b0, 0);

        // Directed cases, 8/8
        run_op("n_add_basic", 1'b1, 16'h0012, 16'h0001, 1'b0, 0);
        run_op("n_sub_neg",   1'b1, 16'h0005, 16'h0007, 1'b1, 0);
        run_op("n_sub_pos",   1'b1, 16'h0007, 16'h0005, 1'b1, 0);
        run_op("n_add_ovf",   1'b1, 16'h007F, 16'h0001, 1'b0, 0);
        run_op("n_sub_ovf",   1'b1, 16'h0080, 16'h0001, 1'b1, 0);
        run_op("n_backpress", 1'b1, 16'h00C3, 16'h0044, 1'b0, 3);

        // Random operations on both instances
        for (int i = 0; i < 24; i++) begin
            run_op("rnd_w", 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
            run_op("rnd_n", 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
